vga_fb_arbiter: RTL and testbench
=================================

Name: vga_fb_arbiter

Overview:
- Shares one framebuffer memory port between two requesters: the display fetch path (feeds the pixel line FIFO ahead of the VGA timing generator) and a writer (drawing/CPU side).
- Serves whole fixed-length bursts, one beat outstanding at a time.
- Display has priority, with an urgent override. A starvation limit guarantees writer progress.
- Sits between the fetch/draw logic and the memory controller, all on vga_CLK.

Parameters:
- ADDR_W, 20, memory word-address width
- DATA_W, 16, memory data width
- BURST_LEN, 16, beats per burst (2..256)
- WR_MAX_WAIT, 64, cycles a pending writer may be deferred by non-urgent display requests (≥1)

Ports:
- vga_CLK  in  1  clock
- rst  in  1  synchronous reset, active-high
- disp_req  in  1  display burst request, held until disp_gnt
- disp_urgent  in  1  display FIFO below low-water mark
- disp_addr  in  ADDR_W  display burst base address
- disp_gnt  out  1  one-cycle pulse, display burst accepted
- disp_rvalid  out  1  read beat valid
- disp_rdata  out  DATA_W  read beat data
- wr_req  in  1  writer burst request, held until wr_gnt
- wr_addr  in  ADDR_W  writer burst base address
- wr_wdata  in  DATA_W  current write beat data
- wr_gnt  out  1  one-cycle pulse, writer burst accepted
- wr_dack  out  1  current write beat consumed; writer advances wr_wdata
- mem_cyc  out  1  burst in progress
- mem_stb  out  1  beat strobe
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  beat address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  beat acknowledge
- mem_rdata  in  DATA_W  read data, valid with mem_ack

Behaviour:
- Interface: reset rst, synchronous, active-high; clock vga_CLK.
- Reset: FSM=IDLE, beat counter=0, wait counter=0. All registered outputs are 0: disp_gnt, wr_gnt, disp_rvalid, disp_rdata, mem_cyc, mem_stb, mem_we, mem_addr.
- Reset mid-burst aborts the burst; any mem_ack arriving while rst is high or in IDLE is ignored.
- FSM states: IDLE, DISP, WR.
- IDLE arbitration, evaluated each cycle in priority order:
  1. disp_req & disp_urgent → DISP.
  2. wr_req & (!disp_req | wait_cnt==WR_MAX_WAIT) → WR.
  3. disp_req → DISP.
  4. Otherwise stay in IDLE.
- On a transition out of IDLE:
  - Pulse the matching gnt for exactly one cycle (the first cycle in DISP/WR).
  - Latch the base address; beat=0.
  - Assert mem_cyc=mem_stb=1 the same cycle; mem_we=1 only in WR.
- Addressing: mem_addr = base + beat, modulo 2^ADDR_W (wraps silently at top of address space).
- A beat completes on any cycle with mem_stb & mem_ack; on completion beat increments.
  - On the BURST_LEN-th ack: mem_cyc and mem_stb drop next cycle, FSM → IDLE.
  - Minimum 1 IDLE cycle between bursts.
- Read path (DISP): disp_rvalid/disp_rdata are registered copies of mem_ack/mem_rdata, so latency is 1 cycle after ack. Exactly BURST_LEN rvalid pulses per grant.
- Write path (WR):
  - mem_wdata = wr_wdata, combinational.
  - wr_dack = mem_ack & state==WR, combinational.
  - Exactly BURST_LEN dack pulses per grant.
- Wait counter:
  - Increments each cycle wr_req=1 and state!=WR; saturates at WR_MAX_WAIT.
  - Cleared on wr_gnt, and when wr_req=0.
- Simultaneous requests:
  - Urgent display beats a starved writer.
  - A non-urgent display loses to the writer once wait_cnt==WR_MAX_WAIT.
- Request changes during a burst do not affect the current burst.
- Deasserting a request before gnt withdraws it; no grant is issued.

Optional Feature:
- Macro: VGA_FB_ARB_TIMEOUT_EN.
- With the macro defined:
  - Add output err (1 bit, reset 0) and an 8-bit ack-timeout counter, cleared on every ack and every new burst.
  - If 255 consecutive cycles pass in DISP/WR without mem_ack: abort the burst (mem_cyc/mem_stb low next cycle, FSM → IDLE) and pulse err for 1 cycle.
  - Remaining beats are not delivered.
- Without the macro: no err port; the arbiter waits for mem_ack indefinitely.

Test Plan:
- Reset defaults: assert rst 3 cycles, with both requests high → no gnt, mem_cyc=0, mem_addr=0. After release, disp_gnt pulses on the first cycle.
- Display burst: disp_req with disp_addr=0x00100 and ack every cycle → mem_addr runs 0x00100..0x0010F; 16 disp_rvalid pulses, each 1 cycle after its ack; then ≥1 idle cycle.
- Write with wait states: wr_req only, wr_addr=0xFFFF8, ack every 3rd cycle → mem_we=1, addresses 0xFFFF8..0xFFFFF then wrap 0x00000..0x00007; 16 wr_dack pulses, each coincident with an ack.
- Starvation:
  - disp_req held continuously non-urgent, plus wr_req → writer granted by the first IDLE cycle at which it has been waiting 64 cycles.
  - Repeat with disp_urgent=1 → display keeps winning.
- Reset mid-burst: rst asserted after 5 acks of a DISP burst → next cycle mem_cyc=0, FSM idle; later acks produce no disp_rvalid.
- Timeout (VGA_FB_ARB_TIMEOUT_EN): hold mem_ack=0 after beat 2 → after 255 cycles err pulses once, mem_cyc drops, and a pending wr_req is then granted.

Source files
------------

// File: rtl/vga_fb_arbiter_if.sv
// vga_fb_arbiter_if: display fetch, writer and framebuffer memory bus
// bundle shared by the arbiter (master) and its environment (slave).
interface vga_fb_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic              disp_req;
    logic              disp_urgent;
    logic [ADDR_W-1:0] disp_addr;
    logic              disp_gnt;
    logic              disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_wdata;
    logic              wr_gnt;
    logic              wr_dack;
    logic              mem_cyc;
    logic              mem_stb;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  disp_req, disp_urgent, disp_addr,
        input  wr_req, wr_addr, wr_wdata,
        input  mem_ack, mem_rdata,
        output disp_gnt, disp_rvalid, disp_rdata,
        output wr_gnt, wr_dack,
        output mem_cyc, mem_stb, mem_we,
        output mem_addr, mem_wdata
    );

    modport slave (
        output disp_req, disp_urgent, disp_addr,
        output wr_req, wr_addr, wr_wdata,
        output mem_ack, mem_rdata,
        input  disp_gnt, disp_rvalid, disp_rdata,
        input  wr_gnt, wr_dack,
        input  mem_cyc, mem_stb, mem_we,
        input  mem_addr, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: display/writer burst arbiter for one framebuffer port.
// Optional ack-timeout abort with err output: VGA_FB_ARB_TIMEOUT_EN.
module vga_fb_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int BURST_LEN   = 16,
    parameter int WR_MAX_WAIT = 64
) (
    input  logic vga_CLK,
    input  logic rst,
`ifdef VGA_FB_ARB_TIMEOUT_EN
    output logic err,
`endif
    vga_fb_arbiter_if.master bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DISP = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    localparam int BW = $clog2(BURST_LEN);
    localparam int WW = $clog2(WR_MAX_WAIT + 1);
    localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);
    localparam logic [WW-1:0] WMAX = WW'(WR_MAX_WAIT);

    logic [1:0]        r_state;
    logic [BW-1:0]     r_beat;
    logic [WW-1:0]     r_wait;
    logic [ADDR_W-1:0] r_addr;
    logic              r_cyc;
    logic              r_stb;
    logic              r_we;
    logic              r_dgnt;
    logic              r_wgnt;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;

    logic w_go_disp;
    logic w_go_wr;
    logic w_beat_done;
    logic w_last;
    logic w_abort;

    assign w_beat_done = r_stb & bus.mem_ack;
    assign w_last      = w_beat_done & (r_beat == LAST);

    always_comb begin
        w_go_disp = 1'b0;
        w_go_wr   = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.disp_req & bus.disp_urgent)
                w_go_disp = 1'b1;
            else if (bus.wr_req &
                     (!bus.disp_req | (r_wait == WMAX)))
                w_go_wr = 1'b1;
            else if (bus.disp_req)
                w_go_disp = 1'b1;
        end
    end

`ifdef VGA_FB_ARB_TIMEOUT_EN
    logic [7:0] r_to;
    logic       r_err;
    logic       w_timeout;

    // 255th consecutive ack-less burst cycle ends the burst
    assign w_timeout = (r_state != S_IDLE) & !bus.mem_ack &
                       (r_to == 8'd254);
    assign w_abort   = w_timeout;
    assign err       = r_err;

    always_ff @(posedge vga_CLK) begin
        if (rst) begin
            r_to  <= 8'd0;
            r_err <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if ((r_state == S_IDLE) | bus.mem_ack)
                r_to <= 8'd0;
            else
                r_to <= r_to + 8'd1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge vga_CLK) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_beat   <= '0;
            r_addr   <= '0;
            r_cyc    <= 1'b0;
            r_stb    <= 1'b0;
            r_we     <= 1'b0;
            r_dgnt   <= 1'b0;
            r_wgnt   <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_dgnt   <= w_go_disp;
            r_wgnt   <= w_go_wr;
            r_rvalid <= (r_state == S_DISP) & w_beat_done;
            if ((r_state == S_DISP) & w_beat_done)
                r_rdata <= bus.mem_rdata;
            case (r_state)
                S_IDLE: begin
                    if (w_go_disp | w_go_wr) begin
                        r_state <= w_go_wr ? S_WR : S_DISP;
                        r_addr  <= w_go_wr ? bus.wr_addr
                                           : bus.disp_addr;
                        r_beat  <= '0;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_we    <= w_go_wr;
                    end
                end
                S_DISP, S_WR: begin
                    if (w_last | w_abort) begin
                        r_state <= S_IDLE;
                        r_cyc   <= 1'b0;
                        r_stb   <= 1'b0;
                        r_we    <= 1'b0;
                    end else if (w_beat_done) begin
                        r_beat <= r_beat + BW'(1);
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cyc   <= 1'b0;
                    r_stb   <= 1'b0;
                    r_we    <= 1'b0;
                end
            endcase
        end
    end

    // Writer starvation window, frozen while its own burst runs
    always_ff @(posedge vga_CLK) begin
        if (rst | !bus.wr_req | w_go_wr)
            r_wait <= '0;
        else if ((r_state != S_WR) & (r_wait != WMAX))
            r_wait <= r_wait + WW'(1);
    end

    assign bus.disp_gnt    = r_dgnt;
    assign bus.wr_gnt      = r_wgnt;
    assign bus.disp_rvalid = r_rvalid;
    assign bus.disp_rdata  = r_rdata;
    assign bus.mem_cyc     = r_cyc;
    assign bus.mem_stb     = r_stb;
    assign bus.mem_we      = r_we;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wdata   = bus.wr_wdata;
    assign bus.wr_dack     = bus.mem_ack & (r_state == S_WR);
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: directed + random stimulus against a burst-level
// reference model with a memory slave and write scoreboard.
module tb_vga_fb_arbiter;
    localparam int AW   = 20;
    localparam int DW   = 16;
    localparam int BL   = 16;
    localparam int MAXW = 64;

    logic vga_CLK = 1'b0;
    logic rst     = 1'b1;
`ifdef VGA_FB_ARB_TIMEOUT_EN
    logic err;
`endif

    vga_fb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vga_fb_arbiter #(
        .ADDR_W(AW), .DATA_W(DW),
        .BURST_LEN(BL), .WR_MAX_WAIT(MAXW)
    ) dut (
        .vga_CLK(vga_CLK),
        .rst(rst),
`ifdef VGA_FB_ARB_TIMEOUT_EN
        .err(err),
`endif
        .bus(bus)
    );

    always #5 vga_CLK = ~vga_CLK;

    int n_chk = 0;
    int n_err = 0;
    int ack_mode = 0;
    int ack_cnt = 0;
    bit drop_d = 0;
    bit drop_w = 0;
    // reference model: who owns the port, progress, writer patience
    int m_own = 0;
    int m_beats = 0;
    int m_base = 0;
    int m_wait = 0;
    int m_to = 0;
    int m_widx0 = 0;
    int wr_idx = 0;
    logic [15:0] wseed = 16'h3C5A;
    logic [15:0] wmem [int];
    int n_dgnt = 0;
    int n_wgnt = 0;
    int n_rv = 0;
    int n_dack = 0;
    int n_errp = 0;

    function automatic logic [15:0] rd_fn(logic [19:0] a);
        return a[15:0] ^ 16'hA5C3 ^ {12'h000, a[19:16]};
    endfunction

    function automatic logic [15:0] wd_fn(int i);
        return wseed ^ 16'(i * 291);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit p_rst = rst;
        bit p_dreq = bus.disp_req;
        bit p_urg = bus.disp_urgent;
        bit p_wreq = bus.wr_req;
        logic [19:0] p_daddr = bus.disp_addr;
        logic [19:0] p_waddr = bus.wr_addr;
        bit p_ack = bus.mem_ack;
        logic [15:0] p_rdata = bus.mem_rdata;
        logic [19:0] p_addr = bus.mem_addr;
        logic [15:0] p_wd = bus.mem_wdata;
        int own0 = m_own;
        bit win_d = 0;
        bit win_w = 0;
        bit exp_rv = 0;
        bit exp_err = 0;
        logic [15:0] exp_rd = 16'h0;
        logic [19:0] ea;
        @(posedge vga_CLK);
        #1;
        if (p_rst) begin
            m_own = 0;
            m_wait = 0;
            m_to = 0;
        end else begin
            if (own0 == 0) begin
                if (p_dreq && p_urg) win_d = 1;
                else if (p_wreq && (!p_dreq || m_wait == MAXW)) win_w = 1;
                else if (p_dreq) win_d = 1;
                if (win_d || win_w) begin
                    m_own = win_d ? 1 : 2;
                    m_base = win_d ? int'(p_daddr) : int'(p_waddr);
                    m_beats = 0;
                    m_to = 0;
                    m_widx0 = wr_idx;
                end
            end else if (p_ack) begin
                m_beats++;
                m_to = 0;
                if (own0 == 1) begin
                    exp_rv = 1;
                    exp_rd = p_rdata;
                end else begin
                    wmem[int'(p_addr)] = p_wd;
                    wr_idx++;
                end
                if (m_beats == BL) begin
                    m_own = 0;
                    if (own0 == 2)
                        for (int k = 0; k < BL; k++) begin
                            ea = 20'(m_base + k);
                            chk("wmem",
                                wmem.exists(int'(ea)) ? wmem[int'(ea)] : 'x,
                                wd_fn(m_widx0 + k));
                        end
                end
            end
`ifdef VGA_FB_ARB_TIMEOUT_EN
            else begin
                m_to++;
                if (m_to == 255) begin
                    m_own = 0;
                    exp_err = 1;
                end
            end
`endif
            if (!p_wreq || win_w) m_wait = 0;
            else if (own0 != 2 && m_wait < MAXW) m_wait++;
        end
        chk("disp_gnt", bus.disp_gnt, win_d);
        chk("wr_gnt", bus.wr_gnt, win_w);
        chk("mem_cyc", bus.mem_cyc, m_own != 0);
        chk("mem_stb", bus.mem_stb, m_own != 0);
        chk("mem_we", bus.mem_we, m_own == 2);
        chk("disp_rvalid", bus.disp_rvalid, exp_rv);
        if (p_rst) begin
            chk("rst_addr", bus.mem_addr, 0);
            chk("rst_rdata", bus.disp_rdata, 0);
        end else if (m_own != 0) begin
            ea = 20'(m_base + m_beats);
            chk("mem_addr", bus.mem_addr, ea);
        end
        if (exp_rv) chk("disp_rdata", bus.disp_rdata, exp_rd);
`ifdef VGA_FB_ARB_TIMEOUT_EN
        chk("err", err, exp_err);
        n_errp += int'(err);
`endif
        n_dgnt += int'(bus.disp_gnt);
        n_wgnt += int'(bus.wr_gnt);
        n_rv += int'(bus.disp_rvalid);
        if (drop_d && bus.disp_gnt) bus.disp_req = 0;
        if (drop_w && bus.wr_gnt) bus.wr_req = 0;
        // memory slave
        case (ack_mode)
            0: bus.mem_ack = bus.mem_stb;
            1: begin
                bus.mem_ack = bus.mem_stb && ack_cnt == 2;
                if (bus.mem_stb) ack_cnt = (ack_cnt + 1) % 3;
            end
            2: bus.mem_ack = 1'($urandom_range(0, 1));
            default: bus.mem_ack = 0;
        endcase
        bus.mem_rdata = bus.mem_ack ? rd_fn(bus.mem_addr)
                                    : 16'($urandom);
        bus.wr_wdata = wd_fn(wr_idx);
        #1;
        chk("wr_dack", bus.wr_dack, bus.mem_ack && m_own == 2);
        n_dack += int'(bus.wr_dack);
        if (m_own == 2) chk("mem_wdata", bus.mem_wdata, wd_fn(wr_idx));
    endtask

    initial begin
        bit found;
        int base;
        bus.disp_req = 1;
        bus.disp_urgent = 0;
        bus.disp_addr = 20'h00100;
        bus.wr_req = 1;
        bus.wr_addr = 20'h00000;
        bus.wr_wdata = wd_fn(0);
        bus.mem_ack = 0;
        bus.mem_rdata = 0;
        rst = 1;
        repeat (3) step();
        chk("rst_no_gnt", n_dgnt + n_wgnt, 0);
        // display burst, ack every cycle
        rst = 0;
        bus.wr_req = 0;
        drop_d = 1;
        drop_w = 1;
        step();
        chk("first_dgnt", bus.disp_gnt, 1);
        repeat (20) step();
        chk("disp_bursts", n_dgnt, 1);
        chk("rv_count", n_rv, BL);
        // write burst across the top of the address space
        bus.wr_addr = 20'hFFFF8;
        bus.wr_req = 1;
        ack_mode = 1;
        ack_cnt = 0;
        base = n_dack;
        repeat (56) step();
        chk("wr_bursts", n_wgnt, 1);
        chk("dack_count", n_dack - base, BL);
        chk("wrap_data", wmem.exists(0) ? wmem[0] : 'x, wd_fn(8));
        // starvation: non-urgent display held, writer must get through
        ack_mode = 0;
        drop_d = 0;
        bus.disp_addr = 20'h12340;
        bus.disp_req = 1;
        bus.wr_addr = 20'h0A000;
        bus.wr_req = 1;
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (bus.wr_gnt) found = 1;
        end
        chk("starve_wgnt", found, 1);
        repeat (20) step();
        // urgent display keeps winning
        bus.disp_urgent = 1;
        bus.wr_req = 1;
        base = n_wgnt;
        repeat (200) step();
        chk("urgent_no_wgnt", n_wgnt - base, 0);
        bus.disp_req = 0;
        bus.disp_urgent = 0;
        bus.wr_req = 0;
        repeat (40) step();
        // reset after 5 acks of a display burst
        drop_d = 1;
        bus.disp_req = 1;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (bus.disp_gnt) found = 1;
        end
        chk("rst_burst_gnt", found, 1);
        repeat (5) step();
        rst = 1;
        ack_mode = 2;
        step();
        chk("rst_cyc", bus.mem_cyc, 0);
        step();
        rst = 0;
        base = n_rv;
        repeat (8) step();
        chk("rst_no_rv", n_rv - base, 0);
`ifdef VGA_FB_ARB_TIMEOUT_EN
        // memory stalls after two beats
        ack_mode = 0;
        bus.disp_req = 1;
        repeat (3) step();
        ack_mode = 3;
        bus.wr_addr = 20'h00400;
        bus.wr_req = 1;
        base = n_errp;
        found = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            step();
            if (bus.wr_gnt) found = 1;
        end
        chk("to_err_pulses", n_errp - base, 1);
        chk("to_wgnt", found, 1);
        ack_mode = 0;
        repeat (20) step();
`endif
        // random traffic
        ack_mode = 2;
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 0) ack_mode = (ack_mode == 2) ? 0 : 2;
            if (!bus.disp_req && $urandom_range(0, 7) == 0) begin
                bus.disp_req = 1;
                bus.disp_addr = 20'($urandom);
            end else if ($urandom_range(0, 29) == 0) begin
                bus.disp_req = 0;
            end
            bus.disp_urgent = ($urandom_range(0, 3) == 0);
            if (!bus.wr_req && $urandom_range(0, 7) == 0) begin
                bus.wr_req = 1;
                bus.wr_addr = 20'($urandom);
            end else if ($urandom_range(0, 29) == 0) begin
                bus.wr_req = 0;
            end
            rst = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 0;
        bus.disp_req = 0;
        bus.wr_req = 0;
        ack_mode = 0;
        repeat (40) step();
        chk("drain_idle", bus.mem_cyc, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
